alsu_gen: RTL and testbench
===========================

# alsu_gen

Parametrised, handshaked successor of the 3-bit ALSU. It registers one operation per accepted input beat and executes logic, reduction, add, shift and rotate in one cycle. Multiply is a multi-cycle shift-add sequence during which input is stalled. It sits between the board input registers and the LED/result display path and drives a registered result, a result-valid strobe and a 16-bit invalid indicator.

## Interface
- WIDTH, 8: operand width, ≥2.
- INPUT_PRIORITY, "A": operand chosen when both bypass or both reduction selects are set; "A" or "B".
- FULL_ADDER, "ON": "ON" adds cin_reg, "OFF" ignores cin.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat; reset 1.
- A, B  in  WIDTH  operands.
- opcode  in  3  operation select.
- cin, serial_in, direction  in  1 each  carry-in, shift-in bit, 1=left / 0=right.
- red_op_A, red_op_B, bypass_A, bypass_B  in  1 each  mode selects.
- out  out  2*WIDTH  registered result; reset 0.
- out_valid  out  1  one-cycle strobe, out updated; reset 0.
- invalid  out  1  last completed op invalid; reset 0.
- leds  out  16  all ones when invalid=1, else 0; reset 0.

## Operation
- Accept: on an edge with in_valid && in_ready, all inputs load into *_reg. The FSM moves IDLE→EXEC.
- EXEC (one cycle). The first matching rule applies:
  - bypass_A_reg && bypass_B_reg: out = zero-extended operand per INPUT_PRIORITY.
  - bypass_A_reg: out = A_reg.
  - bypass_B_reg: out = B_reg.
  - Otherwise by opcode_reg:
    - 000 AND: both red_op → reduction-AND of the priority operand; red_op_A → &A; red_op_B → &B; none → A&B.
    - 001 XOR: same rule, with reduction-XOR and A^B.
    - 010 ADD: A+B(+cin), WIDTH+1 bits, zero-extended.
    - 011 MUL: go to MUL state (see Configuration).
    - 100 SHIFT: direction=1 → {out[2W-2:0], serial_in}; 0 → {serial_in, out[2W-1:1]}.
    - 101 ROTATE: direction=1 → {out[2W-2:0], out[2W-1]}; 0 → {out[0], out[2W-1:1]}.
    - 110, 111: invalid.
  - Any opcode 010–101 with red_op_A_reg or red_op_B_reg set is invalid.
- Invalid op: out ← 0, invalid ← 1, leds ← 16'hFFFF.
- Valid op: invalid ← 0, leds ← 0.
- Completion: out_valid pulses high for one cycle, and the FSM returns to IDLE.
- MUL state: unsigned shift-add over WIDTH cycles, one multiplier bit per cycle, using an internal accumulator. out is held at its old value until done. Completion writes A*B (2*WIDTH bits) to out and pulses out_valid.
- in_ready = 1 only in IDLE. Beats presented while in_ready = 0 are ignored and are not queued.
- Shift and rotate operate on the current out value, so they chain across successive beats.

## Timing
- Beat accepted at edge k → registers loaded at k. Single-cycle ops: out, out_valid, invalid and leds are updated at edge k+1. in_ready is low for the cycle between k and k+1 and high again after k+1.
- Throughput for single-cycle ops: one beat every 2 cycles.
- MUL: result and out_valid at edge k+1+WIDTH. in_ready is low from edge k until the result edge.
- leds updates on the same edge as invalid. There is no extra lag.
- rst asserted at any time, including mid-MUL, immediately clears all registers and the accumulator. The FSM goes to IDLE, in_ready = 1, and the aborted op produces no out_valid.
- out_valid is never high on two consecutive edges.

## Configuration
- ALSU_GEN_MUL_EN defined: opcode 011 runs the multi-cycle multiplier as described.
- ALSU_GEN_MUL_EN undefined: no multiplier or accumulator logic is built. Opcode 011 is invalid (out ← 0, invalid ← 1, single-cycle timing), and in_ready never stays low longer than one cycle.

## Test plan
All scenarios use WIDTH=4, FULL_ADDER="ON", INPUT_PRIORITY="A".
- Reset, then ADD A=4'hF, B=4'h1, cin=1 → one cycle after accept: out=8'h11, out_valid for 1 cycle, invalid=0, leds=0.
- MUL A=4'hD, B=4'hB with macro defined:
  - in_ready low for 5 cycles.
  - out=8'h8F (143) at edge k+5.
  - A beat offered mid-op is ignored.
- Same MUL with macro undefined → out=0, invalid=1, leds=16'hFFFF at edge k+1.
- bypass_A=bypass_B=1, A=4'h3, B=4'h9 → out=8'h03. Opcode 000 with both red_op set, A=4'hF → out=1.
- Chaining:
  - ADD A=4'h5, B=4'h0, cin=0 → out=8'h05.
  - Then SHIFT left with serial_in=1 → 8'h0B.
  - Then ROTATE right → 8'h85.
  - Then opcode 110 → out=0, invalid=1.
  - Then a valid AND → invalid=0.
- rst pulsed at cycle 2 of a MUL → out=0, out_valid stays 0 afterwards, in_ready=1 on the next cycle, and the next op completes normally.

Source files
------------

// File: rtl/alsu_gen.sv
// ============================================================================
//  Module   : alsu_gen
//  Purpose  : Handshaked, parametrised ALSU. Logic, reduction, add, shift and
//             rotate run in one cycle. Multiply is a shift-add sequence that
//             stalls input while it runs.
//  Option   : define ALSU_GEN_MUL_EN to build the multiplier. Without it,
//             opcode 011 is reported as an invalid operation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alsu_gen #(
  parameter int WIDTH          = 8,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           opcode,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 direction,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic                 invalid,
  output logic [15:0]          leds
);

  localparam bit c_PRI_A = (INPUT_PRIORITY == "A");
  localparam bit c_FA_ON = (FULL_ADDER == "ON");
  localparam int c_OW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic [c_OW-1:0]      r_out;
  logic                 r_out_valid;
  logic                 r_invalid;
  logic [15:0]          r_leds;

  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2:0]           r_op;
  logic                 r_cin;
  logic                 r_sin;
  logic                 r_dir;
  logic                 r_red_a;
  logic                 r_red_b;
  logic                 r_byp_a;
  logic                 r_byp_b;

  logic [c_OW-1:0]      w_res;
  logic                 w_inv;
  logic                 w_mul;
  logic [WIDTH:0]       w_sum;
  logic                 w_red_any;

`ifdef ALSU_GEN_MUL_EN
  localparam int c_CW = $clog2(WIDTH);
  logic [c_OW-1:0]      r_acc;
  logic [c_OW-1:0]      r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [c_CW-1:0]      r_cnt;
  logic [c_OW-1:0]      w_acc_next;

  // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {c_OW{1'b0}});
  end
`endif

  // Single-cycle result and invalid decode from the registered beat
  always_comb begin
    w_res     = {c_OW{1'b0}};
    w_inv     = 1'b0;
    w_mul     = 1'b0;
    w_red_any = r_red_a | r_red_b;
    w_sum     = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, (c_FA_ON ? r_cin : 1'b0)};
    if (r_byp_a && r_byp_b) begin
      w_res = {{WIDTH{1'b0}}, (c_PRI_A ? r_a : r_b)};
    end else if (r_byp_a) begin
      w_res = {{WIDTH{1'b0}}, r_a};
    end else if (r_byp_b) begin
      w_res = {{WIDTH{1'b0}}, r_b};
    end else begin
      case (r_op)
        3'b000: begin
          if (r_red_a && r_red_b) w_res = {{(c_OW-1){1'b0}}, (c_PRI_A ? &r_a : &r_b)};
          else if (r_red_a)       w_res = {{(c_OW-1){1'b0}}, &r_a};
          else if (r_red_b)       w_res = {{(c_OW-1){1'b0}}, &r_b};
          else                    w_res = {{WIDTH{1'b0}}, r_a & r_b};
        end
        3'b001: begin
          if (r_red_a && r_red_b) w_res = {{(c_OW-1){1'b0}}, (c_PRI_A ? ^r_a : ^r_b)};
          else if (r_red_a)       w_res = {{(c_OW-1){1'b0}}, ^r_a};
          else if (r_red_b)       w_res = {{(c_OW-1){1'b0}}, ^r_b};
          else                    w_res = {{WIDTH{1'b0}}, r_a ^ r_b};
        end
        3'b010: begin
          if (w_red_any) w_inv = 1'b1;
          else           w_res = {{(WIDTH-1){1'b0}}, w_sum};
        end
        3'b011: begin
`ifdef ALSU_GEN_MUL_EN
          if (w_red_any) w_inv = 1'b1;
          else           w_mul = 1'b1;
`else
          w_inv = 1'b1;
`endif
        end
        3'b100: begin
          if (w_red_any)  w_inv = 1'b1;
          else if (r_dir) w_res = {r_out[c_OW-2:0], r_sin};
          else            w_res = {r_sin, r_out[c_OW-1:1]};
        end
        3'b101: begin
          if (w_red_any)  w_inv = 1'b1;
          else if (r_dir) w_res = {r_out[c_OW-2:0], r_out[c_OW-1]};
          else            w_res = {r_out[0], r_out[c_OW-1:1]};
        end
        default: w_inv = 1'b1;
      endcase
    end
  end

  // Control FSM: accept a beat, execute it, optionally run the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out       <= {c_OW{1'b0}};
      r_out_valid <= 1'b0;
      r_invalid   <= 1'b0;
      r_leds      <= 16'h0000;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_op        <= 3'b000;
      r_cin       <= 1'b0;
      r_sin       <= 1'b0;
      r_dir       <= 1'b0;
      r_red_a     <= 1'b0;
      r_red_b     <= 1'b0;
      r_byp_a     <= 1'b0;
      r_byp_b     <= 1'b0;
`ifdef ALSU_GEN_MUL_EN
      r_acc       <= {c_OW{1'b0}};
      r_mcand     <= {c_OW{1'b0}};
      r_mplier    <= {WIDTH{1'b0}};
      r_cnt       <= {c_CW{1'b0}};
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= A;
            r_b        <= B;
            r_op       <= opcode;
            r_cin      <= cin;
            r_sin      <= serial_in;
            r_dir      <= direction;
            r_red_a    <= red_op_A;
            r_red_b    <= red_op_B;
            r_byp_a    <= bypass_A;
            r_byp_b    <= bypass_B;
            r_in_ready <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef ALSU_GEN_MUL_EN
          if (w_mul) begin
            r_acc    <= {c_OW{1'b0}};
            r_mcand  <= {{WIDTH{1'b0}}, r_a};
            r_mplier <= r_b;
            r_cnt    <= {c_CW{1'b0}};
            r_state  <= S_MUL;
          end else
`endif
          begin
            r_out       <= w_res;
            r_invalid   <= w_inv;
            r_leds      <= {16{w_inv}};
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
`ifdef ALSU_GEN_MUL_EN
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[c_OW-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == c_CW'(WIDTH - 1)) begin
            r_out       <= w_acc_next;
            r_invalid   <= 1'b0;
            r_leds      <= 16'h0000;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
`endif
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign invalid   = r_invalid;
  assign leds      = r_leds;

endmodule

`default_nettype wire

// File: tb/tb_alsu_gen.sv
// ============================================================================
//  Module   : tb_alsu_gen
//  Purpose  : Directed, table-driven bench for alsu_gen (WIDTH=4, adder on,
//             priority A). Multiply expectations follow ALSU_GEN_MUL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alsu_gen;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] opcode;
  logic       cin;
  logic       serial_in;
  logic       direction;
  logic       red_op_A;
  logic       red_op_B;
  logic       bypass_A;
  logic       bypass_B;
  logic [7:0] out;
  logic       out_valid;
  logic       invalid;
  logic [15:0] leds;

  int n_tests;
  int n_fail;

  alsu_gen #(
    .WIDTH          (4),
    .INPUT_PRIORITY ("A"),
    .FULL_ADDER     ("ON")
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .cin       (cin),
    .serial_in (serial_in),
    .direction (direction),
    .red_op_A  (red_op_A),
    .red_op_B  (red_op_B),
    .bypass_A  (bypass_A),
    .bypass_B  (bypass_B),
    .out       (out),
    .out_valid (out_valid),
    .invalid   (invalid),
    .leds      (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic       si;
    logic       dir;
    logic       ra;
    logic       rb;
    logic       ba;
    logic       bb;
    logic [7:0] eo;
    logic       ei;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                              input logic ci, input logic si, input logic dir,
                              input logic ra, input logic rb, input logic ba, input logic bb,
                              input logic [7:0] eo, input logic ei);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ci = ci; v.si = si; v.dir = dir;
    v.ra = ra; v.rb = rb; v.ba = ba; v.bb = bb; v.eo = eo; v.ei = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    A = v.a; B = v.b; opcode = v.op; cin = v.ci; serial_in = v.si; direction = v.dir;
    red_op_A = v.ra; red_op_B = v.rb; bypass_A = v.ba; bypass_B = v.bb;
  endtask

  // Called just after a rising edge; offers one beat and checks the single-cycle result
  task automatic apply(input vec_t v, input int idx);
    check($sformatf("v%0d ready_pre", idx), {31'b0, in_ready}, 32'd1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("v%0d ready_low", idx), {31'b0, in_ready}, 32'd0);
    check($sformatf("v%0d ov_low", idx), {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check($sformatf("v%0d out", idx), {24'b0, out}, {24'b0, v.eo});
    check($sformatf("v%0d out_valid", idx), {31'b0, out_valid}, 32'd1);
    check($sformatf("v%0d invalid", idx), {31'b0, invalid}, {31'b0, v.ei});
    check($sformatf("v%0d leds", idx), {16'b0, leds}, {16'b0, {16{v.ei}}});
    check($sformatf("v%0d ready_post", idx), {31'b0, in_ready}, 32'd1);
  endtask

  vec_t mulv;
  vec_t junk;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //            op     a     b    ci si dir ra rb ba bb  exp    inv
    tbl[0]  = mk(3'b010, 4'hF, 4'h1, 1, 0, 0, 0, 0, 0, 0, 8'h11, 0);
    tbl[1]  = mk(3'b000, 4'h3, 4'h9, 0, 0, 0, 0, 0, 1, 1, 8'h03, 0);
    tbl[2]  = mk(3'b000, 4'hF, 4'h0, 0, 0, 0, 1, 1, 0, 0, 8'h01, 0);
    tbl[3]  = mk(3'b000, 4'hF, 4'hE, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
    tbl[4]  = mk(3'b000, 4'hC, 4'hA, 0, 0, 0, 0, 0, 0, 0, 8'h08, 0);
    tbl[5]  = mk(3'b001, 4'h6, 4'h0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    tbl[6]  = mk(3'b001, 4'h0, 4'h7, 0, 0, 0, 0, 1, 0, 0, 8'h01, 0);
    tbl[7]  = mk(3'b001, 4'h1, 4'h3, 0, 0, 0, 1, 1, 0, 0, 8'h01, 0);
    tbl[8]  = mk(3'b001, 4'h6, 4'h3, 0, 0, 0, 0, 0, 0, 0, 8'h05, 0);
    tbl[9]  = mk(3'b010, 4'h2, 4'h2, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1);
    tbl[10] = mk(3'b010, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 8'h1E, 0);
    tbl[11] = mk(3'b010, 4'h5, 4'h0, 0, 0, 0, 0, 0, 0, 0, 8'h05, 0);
    tbl[12] = mk(3'b100, 4'h0, 4'h0, 0, 1, 1, 0, 0, 0, 0, 8'h0B, 0);
    tbl[13] = mk(3'b101, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 8'h85, 0);
    tbl[14] = mk(3'b110, 4'h1, 4'h1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    tbl[15] = mk(3'b000, 4'hF, 4'h3, 0, 0, 0, 0, 0, 0, 0, 8'h03, 0);
    tbl[16] = mk(3'b000, 4'h0, 4'h9, 0, 0, 0, 0, 0, 0, 1, 8'h09, 0);
    tbl[17] = mk(3'b100, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 8'h84, 0);
    tbl[18] = mk(3'b101, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 8'h09, 0);
    tbl[19] = mk(3'b101, 4'h0, 4'h0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 1);
    tbl[20] = mk(3'b111, 4'h7, 4'h0, 0, 0, 0, 0, 0, 1, 0, 8'h07, 0);
    tbl[21] = mk(3'b111, 4'h7, 4'h0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);

    mulv = mk(3'b011, 4'hD, 4'hB, 0, 0, 0, 0, 0, 0, 0, 8'h8F, 0);
    junk = mk(3'b010, 4'h1, 4'h1, 0, 0, 0, 0, 0, 0, 0, 8'h02, 0);

    rst = 1'b1;
    in_valid = 1'b0;
    drive(mk(3'b000, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    #12;
    check("rst out", {24'b0, out}, 32'd0);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst invalid", {31'b0, invalid}, 32'd0);
    check("rst leds", {16'b0, leds}, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) apply(tbl[i], i);

    // Multiply: stall, ignored mid-op beat, result at k+1+WIDTH
`ifdef ALSU_GEN_MUL_EN
    drive(mulv);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("mul ready_k", {31'b0, in_ready}, 32'd0);
    drive(junk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("mul ready_c%0d", c), {31'b0, in_ready}, 32'd0);
      check($sformatf("mul ov_c%0d", c), {31'b0, out_valid}, 32'd0);
      check($sformatf("mul hold_c%0d", c), {24'b0, out}, {24'b0, tbl[NV-1].eo});
      if (c == 4) in_valid = 1'b0;
    end
    @(posedge clk); #1;
    check("mul out", {24'b0, out}, 32'h8F);
    check("mul out_valid", {31'b0, out_valid}, 32'd1);
    check("mul invalid", {31'b0, invalid}, 32'd0);
    check("mul leds", {16'b0, leds}, 32'd0);
    check("mul ready_done", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("mul ov_after", {31'b0, out_valid}, 32'd0);
    check("mul not_queued", {24'b0, out}, 32'h8F);
    check("mul ready_after", {31'b0, in_ready}, 32'd1);
`else
    mulv.eo = 8'h00;
    mulv.ei = 1'b1;
    apply(mulv, 100);
`endif

    // Reset in the middle of an operation aborts it without out_valid
    drive(mk(3'b011, 4'h3, 4'h5, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst out", {24'b0, out}, 32'd0);
    check("arst ready", {31'b0, in_ready}, 32'd1);
    check("arst invalid", {31'b0, invalid}, 32'd0);
    check("arst leds", {16'b0, leds}, 32'd0);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("arst ov_c%0d", c), {31'b0, out_valid}, 32'd0);
    end
    check("arst ready_next", {31'b0, in_ready}, 32'd1);
    apply(tbl[0], 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
